// File: rtl/idli_salu_m.sv
// Multi-cycle serial ALU: LSB-first slice beats with persistent Z/N/C/V flags.
// Optional IDLI_SALU_SUB_EN enables the rhs inverter for SUB/CMP.
module idli_salu_m #(
   parameter int unsigned SLICE_W = 4,
   parameter int unsigned DATA_W  = 16,
   localparam int unsigned BEATS  = DATA_W / SLICE_W,
   localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic               i_salu_gck,
   input  logic               i_salu_rst_n,
   input  logic               i_salu_start,
   input  logic [2:0]         i_salu_op,
   input  logic [SLICE_W-1:0] i_salu_lhs,
   input  logic [SLICE_W-1:0] i_salu_rhs,
   output logic [CNT_W-1:0]   o_salu_beat,
   output logic               o_salu_busy,
   output logic [SLICE_W-1:0] o_salu_out,
   output logic               o_salu_out_vld,
   output logic               o_salu_done,
   output logic [3:0]         o_salu_flags
);

   localparam logic [2:0] OpAdd  = 3'd0;
   localparam logic [2:0] OpAnd  = 3'd1;
   localparam logic [2:0] OpOr   = 3'd2;
   localparam logic [2:0] OpXor  = 3'd3;
   localparam logic [2:0] OpSub  = 3'd4;
   localparam logic [2:0] OpCmp  = 3'd5;
   localparam logic [2:0] OpAddc = 3'd6;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   state_t             r_state, w_state_nxt;
   logic [2:0]         r_op;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_carry;
   logic               r_zacc;
   logic [3:0]         r_flags;

   logic               w_start_ok;
   logic               w_last;
   logic               w_sub;
   logic               w_arith;
   logic               w_carry_init;
   logic [SLICE_W-1:0] w_rhs_eff;
   logic [SLICE_W:0]   w_sum;
   logic               w_cout;
   logic               w_v;

   assign w_start_ok = i_salu_start && (r_state != StRun);
   assign w_last     = (r_state == StRun) && (r_cnt == CNT_W'(BEATS - 1));
   assign w_arith    = (r_op == OpAdd) || (r_op == OpSub) || (r_op == OpCmp) || (r_op == OpAddc);

`ifdef IDLI_SALU_SUB_EN
   assign w_sub = (r_op == OpSub) || (r_op == OpCmp);
`else
   assign w_sub = 1'b0;
`endif

   assign w_rhs_eff = w_sub ? ~i_salu_rhs : i_salu_rhs;
   assign w_sum     = {1'b0, i_salu_lhs} + {1'b0, w_rhs_eff} + {{SLICE_W{1'b0}}, r_carry};
   assign w_cout    = w_sum[SLICE_W];
   // Carry into the MSB recovered from the MSB sum bit and its two addend bits.
   assign w_v       = w_cout ^ (i_salu_lhs[SLICE_W-1] ^ w_rhs_eff[SLICE_W-1] ^ w_sum[SLICE_W-1]);

   always_comb begin
      o_salu_out = i_salu_lhs ^ i_salu_rhs;
      case (r_op)
         OpAnd:                      o_salu_out = i_salu_lhs & i_salu_rhs;
         OpOr:                       o_salu_out = i_salu_lhs | i_salu_rhs;
         OpAdd, OpSub, OpCmp, OpAddc: o_salu_out = w_sum[SLICE_W-1:0];
         default:                    o_salu_out = i_salu_lhs ^ i_salu_rhs;
      endcase
   end

   always_comb begin
      w_carry_init = 1'b0;
      case (i_salu_op)
`ifdef IDLI_SALU_SUB_EN
         OpSub, OpCmp: w_carry_init = 1'b1;
`endif
         OpAddc:       w_carry_init = r_flags[1];
         default:      w_carry_init = 1'b0;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StIdle:  if (i_salu_start) w_state_nxt = StRun;
         StRun:   if (w_last) w_state_nxt = StDone;
         StDone:  w_state_nxt = i_salu_start ? StRun : StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge i_salu_gck or negedge i_salu_rst_n) begin
      if (!i_salu_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Idle op of XOR keeps o_salu_out as lhs^rhs out of reset.
   always_ff @(posedge i_salu_gck or negedge i_salu_rst_n) begin
      if (!i_salu_rst_n) begin
         r_op    <= OpXor;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_zacc  <= 1'b0;
         r_flags <= 4'b0;
      end else if (w_start_ok) begin
         r_op    <= i_salu_op;
         r_cnt   <= '0;
         r_carry <= w_carry_init;
         r_zacc  <= 1'b1;
      end else if (r_state == StRun) begin
         r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
         r_carry <= w_arith ? w_cout : r_carry;
         r_zacc  <= r_zacc & (o_salu_out == '0);
         if (w_last) begin
            r_flags <= {r_zacc & (o_salu_out == '0), o_salu_out[SLICE_W-1],
                        w_arith & w_cout, w_arith & w_v};
         end
      end
   end

   assign o_salu_busy    = (r_state == StRun);
   assign o_salu_out_vld = o_salu_busy && (r_op != OpCmp);
   assign o_salu_done    = (r_state == StDone);
   assign o_salu_beat    = r_cnt;
   assign o_salu_flags   = r_flags;

endmodule

// File: tb/tb_idli_salu_m.sv
// Bench for idli_salu_m: three widths (4/16, 1/8, 8/32) checked against a
// whole-word arithmetic model; operand slices are served by o_salu_beat.
module tb_idli_salu_m;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        st  [3];
   logic [2:0]  opv [3];
   logic [31:0] la  [3];
   logic [31:0] rb  [3];
   logic        busy[3];
   logic        vld [3];
   logic        done[3];
   logic [3:0]  flg [3];

   logic [1:0] beat0;  logic [3:0] out0, lhs0, rhs0;
   logic [2:0] beat1;  logic       out1, lhs1, rhs1;
   logic [1:0] beat2;  logic [7:0] out2, lhs2, rhs2;

   assign lhs0 = la[0][32'(beat0) * 4 +: 4];
   assign rhs0 = rb[0][32'(beat0) * 4 +: 4];
   assign lhs1 = la[1][32'(beat1)];
   assign rhs1 = rb[1][32'(beat1)];
   assign lhs2 = la[2][32'(beat2) * 8 +: 8];
   assign rhs2 = rb[2][32'(beat2) * 8 +: 8];

   idli_salu_m #(.SLICE_W(4), .DATA_W(16)) u0 (
      .i_salu_gck(clk), .i_salu_rst_n(rst_n), .i_salu_start(st[0]), .i_salu_op(opv[0]),
      .i_salu_lhs(lhs0), .i_salu_rhs(rhs0), .o_salu_beat(beat0), .o_salu_busy(busy[0]),
      .o_salu_out(out0), .o_salu_out_vld(vld[0]), .o_salu_done(done[0]),
      .o_salu_flags(flg[0]));
   idli_salu_m #(.SLICE_W(1), .DATA_W(8)) u1 (
      .i_salu_gck(clk), .i_salu_rst_n(rst_n), .i_salu_start(st[1]), .i_salu_op(opv[1]),
      .i_salu_lhs(lhs1), .i_salu_rhs(rhs1), .o_salu_beat(beat1), .o_salu_busy(busy[1]),
      .o_salu_out(out1), .o_salu_out_vld(vld[1]), .o_salu_done(done[1]),
      .o_salu_flags(flg[1]));
   idli_salu_m #(.SLICE_W(8), .DATA_W(32)) u2 (
      .i_salu_gck(clk), .i_salu_rst_n(rst_n), .i_salu_start(st[2]), .i_salu_op(opv[2]),
      .i_salu_lhs(lhs2), .i_salu_rhs(rhs2), .o_salu_beat(beat2), .o_salu_busy(busy[2]),
      .o_salu_out(out2), .o_salu_out_vld(vld[2]), .o_salu_done(done[2]),
      .o_salu_flags(flg[2]));

   int nvec = 0;
   int nerr = 0;
   logic [3:0] ef[3];  // model's view of each unit's flags

   function automatic int dw_of(input int i);
      return (i == 0) ? 16 : (i == 1) ? 8 : 32;
   endfunction
   function automatic int sw_of(input int i);
      return (i == 0) ? 4 : (i == 1) ? 1 : 8;
   endfunction
   function automatic logic [7:0] g_out(input int i);
      return (i == 0) ? 8'(out0) : (i == 1) ? 8'(out1) : out2;
   endfunction
   function automatic logic [7:0] g_beat(input int i);
      return (i == 0) ? 8'(beat0) : (i == 1) ? 8'(beat1) : 8'(beat2);
   endfunction

   // Whole-word reference: returns {Z,N,C,V, result}.
   function automatic logic [35:0] model(input int dw, input logic [2:0] op,
                                         input logic [31:0] a_in, input logic [31:0] b_in,
                                         input logic cprev);
      logic [63:0] m, a, b, s;
      logic [31:0] r;
      logic c, v, sub, ar;
      m = (64'd1 << dw) - 64'd1;
      a = {32'b0, a_in} & m;
      b = {32'b0, b_in} & m;
      c = 1'b0; v = 1'b0; sub = 1'b0; ar = 1'b1;
      case (op)
         3'd0, 3'd6: begin
            s = a + b + ((op == 3'd6) ? 64'(cprev) : 64'd0);
            c = s[dw];
         end
         3'd4, 3'd5: begin
`ifdef IDLI_SALU_SUB_EN
            s = (a - b) & m;
            c = (a >= b);
            sub = 1'b1;
`else
            s = a + b;
            c = s[dw];
`endif
         end
         3'd1:    begin s = a & b; ar = 1'b0; end
         3'd2:    begin s = a | b; ar = 1'b0; end
         default: begin s = a ^ b; ar = 1'b0; end
      endcase
      r = 32'(s & m);
      if (ar) v = (a[dw-1] == (b[dw-1] ^ sub)) && (r[dw-1] != a[dw-1]);
      return {r == 32'd0, r[dw-1], c, v, r};
   endfunction

   // Caller is at a negedge; start is raised now and sampled at the next posedge.
   task automatic run_op(input int i, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit poke, output logic [31:0] res,
                         output logic [3:0] flags, output int lat, output int vld_n,
                         output bit beat_ok, output bit busy_ok);
      st[i] = 1'b1; opv[i] = op; la[i] = a; rb[i] = b;
      res = '0; flags = '0; lat = 0; vld_n = 0; beat_ok = 1'b1; busy_ok = 1'b1;
      @(posedge clk);
      #1 st[i] = 1'b0;
      for (int n = 1; n <= 64; n++) begin
         @(negedge clk);
         if (poke) begin
            st[i] = (n == 3);
            if (n == 3) opv[i] = 3'd1;
         end
         if (done[i]) begin
            lat = n; flags = flg[i];
            st[i] = 1'b0;
            break;
         end
         if (busy[i]) begin
            if (g_beat(i) != 8'(n - 1)) beat_ok = 1'b0;
            res = res | (32'(g_out(i)) << ((n - 1) * sw_of(i)));
            if (vld[i]) vld_n++;
         end else begin
            busy_ok = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin st[i] = 0; opv[i] = 0; la[i] = 0; rb[i] = 0; ef[i] = 0; end
      la[0] = 32'h0000_000A; rb[0] = 32'h0000_0006;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         nvec++;
         if ({busy[i], vld[i], done[i], g_beat(i), flg[i]} !== 15'd0) begin
            nerr++;
            $display("FAIL reset_state[%0d] got busy%b vld%b done%b beat%0d flags%b want all 0",
                     i, busy[i], vld[i], done[i], g_beat(i), flg[i]);
         end
      end
      nvec++;
      if (out0 !== 4'hC) begin
         nerr++; $display("FAIL reset_out_xor got %h want c", out0);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      nvec++;
      if ({busy[0], done[0], flg[0]} !== 6'd0) begin
         nerr++; $display("FAIL idle_after_reset got busy%b done%b flags%b", busy[0], done[0], flg[0]);
      end
   endtask

   // Directed op on unit 0 compared against constants.
   task automatic directed(input string nm, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input bit b2b, input logic [15:0] er,
                           input logic [3:0] efl, input int evld);
      logic [31:0] res; logic [3:0] f; int lat, vn; bit bo, bu;
      if (!b2b) @(negedge clk);
      run_op(0, op, a, b, 1'b0, res, f, lat, vn, bo, bu);
      nvec++;
      if ({res[15:0], f, 8'(lat), 8'(vn), bo, bu} !== {er, efl, 8'd5, 8'(evld), 2'b11}) begin
         nerr++;
         $display("FAIL %s got res=%h flags=%b lat=%0d vld=%0d beat_ok=%b busy_ok=%b want res=%h flags=%b lat=5 vld=%0d",
                  nm, res[15:0], f, lat, vn, bo, bu, er, efl, evld);
      end
      ef[0] = efl;
   endtask

   task automatic test_arith();
      directed("add_00ff_0001", 3'd0, 32'h00FF, 32'h0001, 1'b0, 16'h0100, 4'b0000, 4);
`ifdef IDLI_SALU_SUB_EN
      directed("sub_5_7", 3'd4, 32'h0005, 32'h0007, 1'b0, 16'hFFFE, 4'b0100, 4);
`else
      directed("op4_as_add", 3'd4, 32'h0005, 32'h0007, 1'b0, 16'h000C, 4'b0000, 4);
`endif
      directed("add_7fff_0001", 3'd0, 32'h7FFF, 32'h0001, 1'b0, 16'h8000, 4'b0101, 4);
   endtask

   task automatic test_cmp_logic();
`ifdef IDLI_SALU_SUB_EN
      directed("cmp_equal", 3'd5, 32'h1234, 32'h1234, 1'b0, 16'h0000, 4'b1010, 0);
`else
      directed("op5_flag_add", 3'd5, 32'h1234, 32'h1234, 1'b0, 16'h2468, 4'b0000, 0);
`endif
      directed("and_f0f0_0f0f", 3'd1, 32'hF0F0, 32'h0F0F, 1'b0, 16'h0000, 4'b1000, 4);
      directed("or_mix", 3'd2, 32'h8001, 32'h0100, 1'b0, 16'h8101, 4'b0100, 4);
   endtask

   task automatic test_back_to_back();
      directed("add_ffff_0001", 3'd0, 32'hFFFF, 32'h0001, 1'b0, 16'h0000, 4'b1010, 4);
      directed("addc_b2b", 3'd6, 32'h0000, 32'h0000, 1'b1, 16'h0001, 4'b0000, 4);
   endtask

   task automatic test_start_in_run();
      logic [31:0] res; logic [3:0] f; int lat, vn; bit bo, bu;
      @(negedge clk);
      run_op(0, 3'd0, 32'h1234, 32'h4321, 1'b1, res, f, lat, vn, bo, bu);
      nvec++;
      if ({res[15:0], f, 8'(lat), 8'(vn), bo, bu} !== {16'h5555, 4'b0000, 8'd5, 8'd4, 2'b11}) begin
         nerr++;
         $display("FAIL start_in_run got res=%h flags=%b lat=%0d vld=%0d beat_ok=%b busy_ok=%b want res=5555 flags=0000 lat=5 vld=4",
                  res[15:0], f, lat, vn, bo, bu);
      end
      ef[0] = 4'b0000;
      repeat (2) @(negedge clk);
      nvec++;
      if ({busy[0], done[0]} !== 2'b00) begin
         nerr++; $display("FAIL idle_after_poke got busy%b done%b want 00", busy[0], done[0]);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] res; logic [3:0] f; int lat, vn; bit bo, bu, seen;
      directed("add_set_carry", 3'd0, 32'hFFFF, 32'h0001, 1'b0, 16'h0000, 4'b1010, 4);
      @(negedge clk);
      st[0] = 1'b1; opv[0] = 3'd0; la[0] = 32'h1111; rb[0] = 32'h2222;
      @(posedge clk);
      #1 st[0] = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      nvec++;
      if ({busy[0], vld[0], done[0], beat0, flg[0]} !== 9'd0 || out0 !== 4'h3) begin
         nerr++;
         $display("FAIL reset_mid got busy%b vld%b done%b beat%0d flags%b out=%h want 0,0,0,0,0000,3",
                  busy[0], vld[0], done[0], beat0, flg[0], out0);
      end
      for (int i = 0; i < 3; i++) ef[i] = 4'b0;
      seen = 1'b0;
      repeat (3) begin @(negedge clk); if (done[0]) seen = 1'b1; end
      rst_n = 1'b1;
      repeat (6) begin @(negedge clk); if (done[0]) seen = 1'b1; end
      nvec++;
      if (seen !== 1'b0) begin
         nerr++; $display("FAIL aborted_no_done got done seen=%b want 0", seen);
      end
      // Carry flag was cleared, so ADDC adds nothing extra.
      run_op(0, 3'd6, 32'h0001, 32'h0002, 1'b0, res, f, lat, vn, bo, bu);
      nvec++;
      if ({res[15:0], f, 8'(lat)} !== {16'h0003, 4'b0000, 8'd5}) begin
         nerr++;
         $display("FAIL addc_after_reset got res=%h flags=%b lat=%0d want 0003 0000 5", res[15:0], f, lat);
      end
   endtask

   task automatic test_random();
      logic [31:0] res, a, b; logic [3:0] f; logic [2:0] op; logic [35:0] e;
      int lat, vn, i, bt, evld; bit bo, bu;
      for (int it = 0; it < 60; it++) begin
         i  = it % 3;
         op = 3'($urandom_range(0, 6));
         a  = $urandom; b = $urandom;
         if (it % 7 == 0) b = ~a;
         if ($urandom_range(0, 1) == 0) @(negedge clk);
         e    = model(dw_of(i), op, a, b, ef[i][1]);
         bt   = dw_of(i) / sw_of(i);
         evld = (op == 3'd5) ? 0 : bt;
         run_op(i, op, a, b, 1'b0, res, f, lat, vn, bo, bu);
         if (op == 3'd5) res = e[31:0];
         nvec++;
         if ({res, f, 8'(lat), 8'(vn), bo, bu} !== {e[31:0], e[35:32], 8'(bt + 1), 8'(evld), 2'b11}) begin
            nerr++;
            $display("FAIL rand[%0d] unit%0d op%0d a=%h b=%h got res=%h flags=%b lat=%0d vld=%0d beat_ok=%b busy_ok=%b want res=%h flags=%b lat=%0d vld=%0d",
                     it, i, op, a, b, res, f, lat, vn, bo, bu, e[31:0], e[35:32], bt + 1, evld);
         end
         ef[i] = e[35:32];
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_arith();
      test_cmp_logic();
      test_back_to_back();
      test_start_in_run();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/idli_salu_m.md
# idli_salu_m

Parametrised multi-cycle serial ALU, the successor to the core's fixed 4b slice ALU. It processes a DATA_W-bit operation as DATA_W/SLICE_W LSB-first beats and owns its own beat counter, carry chain and sequencing. It produces Z/N/C/V flags that persist between operations, which enables compare and multi-word add-with-carry. It sits between the register-file slice read ports and the writeback path, driven by the decoder through a start/done handshake.

## Interface
Parameters:
- SLICE_W, 4, bits processed per beat (≥1).
- DATA_W, 16, full operand width; multiple of SLICE_W; BEATS = DATA_W/SLICE_W ≥ 2.

Ports:
- i_salu_gck  in  1  clock; one clock domain, all state on rising edge.
- i_salu_rst_n  in  1  reset, asynchronous, active-low.
- i_salu_start  in  1  request; accepted only in IDLE or DONE.
- i_salu_op  in  3  operation, sampled with an accepted start: 0 ADD, 1 AND, 2 OR, 3 XOR, 4 SUB, 5 CMP, 6 ADDC, 7 reserved (behaves as XOR).
- i_salu_lhs  in  SLICE_W  lhs slice for current beat.
- i_salu_rhs  in  SLICE_W  rhs slice for current beat.
- o_salu_beat  out  max(1,$clog2(BEATS))  index of the slice the operand sources must present.
- o_salu_busy  out  1  high during RUN beats.
- o_salu_out  out  SLICE_W  result slice (combinational from operands, op and carry).
- o_salu_out_vld  out  1  result slice to be written; busy & op≠CMP.
- o_salu_done  out  1  one-cycle pulse after the last beat.
- o_salu_flags  out  4  {Z,N,C,V}, registered, held until the next done.

## Operation
- States: IDLE → RUN on start; RUN → DONE after beat BEATS-1; DONE → RUN if start, else IDLE.
- On an accepted start:
  - op is latched.
  - Beat counter is cleared to 0.
  - carry_q is loaded: 0 for ADD; 1 for SUB/CMP; the current C flag for ADDC; 0 for logic ops.
  - zero-accumulator is set to 1.
- Each RUN beat:
  - ADD/ADDC: {cout,out} = lhs + rhs + carry_q.
  - SUB/CMP: same with ~rhs.
  - AND/OR/XOR: bitwise.
  - carry_q ← cout for arithmetic ops.
  - zero-accumulator &= (out == 0).
  - Counter increments.
- After the final beat, the flags register is written (visible in DONE):
  - Z = zero-accumulator.
  - N = MSB of the final slice.
  - C = final carry for arithmetic ops, 0 for logic. For SUB/CMP, C = 1 means no borrow.
  - V = signed overflow (carry into MSB xor carry out) for arithmetic ops, 0 for logic.
- CMP: out_vld stays low; only the flags change.
- Start while in RUN is ignored; the op in progress continues undisturbed.
- Reset (any time, including mid-op):
  - State returns to IDLE; carry, counter, accumulator and flags are cleared.
  - busy/out_vld/done/beat are 0; o_salu_out reflects XOR of the inputs.
  - The aborted op produces no done pulse.

## Timing
- Start accepted at cycle T:
  - Beats occur at T+1 … T+BEATS; operand slice k is presented at T+1+k, when o_salu_beat = k.
  - o_salu_busy/out_vld are high T+1 … T+BEATS.
  - o_salu_done pulses at T+BEATS+1; o_salu_flags are valid from T+BEATS+1.
- Back-to-back: start asserted in the DONE cycle begins its first beat the following cycle. Issue interval is BEATS+1 cycles.
- ADDC started in the DONE cycle of a previous op uses that op's just-written C.
- o_salu_out is combinational within a beat; there is no registered result path.

## Configuration
- IDLI_SALU_SUB_EN:
  - Defined: SUB and CMP are implemented as above.
  - Undefined: no rhs inverter. Op 4 behaves as ADD and op 5 as ADD with out_vld low (flag-only add). Carry-in for both is 0.

## Test plan
- ADD 0x00FF+0x0001 (SLICE_W=4, DATA_W=16) -> out slices 0,0,1,0 on beats 0–3; done at T+5; flags Z0 N0 C0 V0.
- SUB 0x0005−0x0007 -> result 0xFFFE; flags Z0 N1 C0 V0. ADD 0x7FFF+0x0001 -> 0x8000; flags N1 V1 C0.
- CMP 0x1234 vs 0x1234 -> out_vld never high; flags Z1 N0 C1 V0. Then AND 0xF0F0&0x0F0F -> 0x0000; Z1, C0, V0.
- ADD 0xFFFF+0x0001 (C=1, Z=1), then ADDC 0x0000+0x0000 started in the DONE cycle -> result 0x0001, C0, no idle cycle between ops.
- Start pulsed during beat 2 of an ADD -> ignored, op completes normally. Reset asserted at beat 2 -> busy/out_vld drop immediately, no done, flags 0, next start behaves as from reset.
- Parameter sweep SLICE_W=1/DATA_W=8 and SLICE_W=8/DATA_W=32 -> random ADD/SUB/logic ops match a reference model, with done at T+BEATS+1.
